// File: rtl/input_cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : input_cond_pkg
//  Description : Shared constants for the switch / push-button front-end.
//  Revision    : 1.0  initial release
// ============================================================================
package input_cond_pkg;

    // Debounce length: 20 ms at 50 MHz on the board, short for simulation
    localparam int DEB_CYCLES_DEFAULT = 1000000;
    localparam int DEB_CYCLES_SIM     = 8;

    // Depth of the metastability synchroniser on every raw input
    localparam int SYNC_STAGES        = 2;

    // Meaning of the individual key / switch bits for the menu FSM
    localparam int KEY_NEXT           = 0;
    localparam int SW_SEL0            = 0;
    localparam int SW_SEL1            = 1;
    localparam int SW_SEL2            = 2;
    localparam int SW_SEL3            = 3;

endpackage : input_cond_pkg
`default_nettype wire

// File: rtl/debounce_cell.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_cell
//  Description : One input bit: 2-FF synchroniser, stability counter and
//                accepted (stable) level. A change is accepted only after the
//                synchronised value has differed from the stable value for
//                DEB_CYCLES consecutive cycles; any glitch restarts the count.
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_cell
    import input_cond_pkg::*;
#(
    parameter logic RESET_VAL  = 1'b0,
    parameter int   DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int   CNT_W      = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_stable
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_q;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    // Synchroniser chain; resets to the idle level of the input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Count consecutive disagreeing cycles; accept the new level at the end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_q   <= RESET_VAL;
        end else if (w_s == r_q) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_q   <= w_s;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_stable = r_q;

endmodule : debounce_cell
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : input_conditioner
//  Description : Synchronises and debounces the slide switches and the
//                active-low push-buttons, latches each press as an event held
//                until acknowledged (with a sticky overrun flag), pulses on
//                switch rising edges and snapshots the switches at each press.
//  Revision    : 1.0  initial release
// ============================================================================
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int N_KEY      = 2,
    parameter int N_SW       = 4,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = 20
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [N_KEY-1:0] KEY,
    input  logic [N_SW-1:0]  SW,
    input  logic [N_KEY-1:0] KEY_ACK,
    output logic [N_KEY-1:0] KEY_DOWN,
    output logic [N_KEY-1:0] KEY_EVT,
    output logic [N_KEY-1:0] KEY_OVR,
    output logic [N_SW-1:0]  SW_DB,
    output logic [N_SW-1:0]  SW_RISE,
    output logic [N_SW-1:0]  SW_SNAP
);

    localparam int N_IN = N_KEY + N_SW;

    logic [N_IN-1:0]  w_raw;
    logic [N_IN-1:0]  w_q;
    logic [N_KEY-1:0] w_qkey;
    logic [N_SW-1:0]  w_qsw;
    logic [N_KEY-1:0] w_press;

    logic [N_KEY-1:0] r_qkey_d;
    logic [N_SW-1:0]  r_qsw_d;
    logic [N_KEY-1:0] r_key_down;
    logic [N_KEY-1:0] r_key_evt;
    logic [N_KEY-1:0] r_key_ovr;
    logic [N_SW-1:0]  r_sw_db;
    logic [N_SW-1:0]  r_sw_rise;
    logic [N_SW-1:0]  r_sw_snap;

    // Keys occupy the low bits, switches the high bits
    assign w_raw = {SW, KEY};

    for (genvar g = 0; g < N_IN; g++) begin : g_deb
        debounce_cell #(
            .RESET_VAL  ((g < N_KEY) ? 1'b1 : 1'b0),
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_cell (
            .clk      (CLOCK_50),
            .rst_n    (RESET_N),
            .i_raw    (w_raw[g]),
            .o_stable (w_q[g])
        );
    end

    assign w_qkey  = w_q[N_KEY-1:0];
    assign w_qsw   = w_q[N_KEY +: N_SW];

    // A press is the stable key level falling from released (1) to pressed (0)
    assign w_press = r_qkey_d & ~w_qkey;

    // Delayed stable levels plus the registered level / edge outputs
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_qkey_d   <= '1;
            r_qsw_d    <= '0;
            r_key_down <= '0;
            r_sw_db    <= '0;
            r_sw_rise  <= '0;
        end else begin
            r_qkey_d   <= w_qkey;
            r_qsw_d    <= w_qsw;
            r_key_down <= ~w_qkey;
            r_sw_db    <= w_qsw;
            r_sw_rise  <= w_qsw & ~r_qsw_d;
        end
    end

    // Event latch: a new press beats a same-cycle acknowledge
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_key_evt <= '0;
        end else begin
            r_key_evt <= w_press | (r_key_evt & ~KEY_ACK);
        end
    end

    // Overrun: press on a still-pending, unacknowledged event; ack w/o press clears
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_key_ovr <= '0;
        end else begin
            r_key_ovr <= (w_press & r_key_evt & ~KEY_ACK)
                       | (r_key_ovr & ~(KEY_ACK & ~w_press));
        end
    end

    // Capture the registered switch levels whenever any press is accepted
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sw_snap <= '0;
        end else if (|w_press) begin
            r_sw_snap <= r_sw_db;
        end
    end

    assign KEY_DOWN = r_key_down;
    assign KEY_EVT  = r_key_evt;
    assign KEY_OVR  = r_key_ovr;
    assign SW_DB    = r_sw_db;
    assign SW_RISE  = r_sw_rise;
    assign SW_SNAP  = r_sw_snap;

endmodule : input_conditioner
`default_nettype wire
